// File: rtl/uart_tx_fifo.sv
// Show-ahead byte FIFO between the bus-side register file and the UART TX controller.
// Serves the controller's load/full/pull handshake and keeps occupancy, low-water and error flags.
module uart_tx_fifo #(
   parameter int unsigned DATA_UART  = 8,
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  flush_i,
   input  logic                  wr_en_i,
   input  logic [DATA_UART-1:0]  wr_data_i,
   input  logic                  clear_flags_i,
   input  logic [DEPTH_LOG2:0]   thr_i,
   input  logic                  tx_pull_i,
   output logic                  tx_load_o,
   output logic [DATA_UART-1:0]  tx_data_o,
   output logic                  full_o,
   output logic [DEPTH_LOG2:0]   count_o,
   output logic                  below_thr_o,
   output logic                  overflow_o,
   output logic                  underflow_o
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [DATA_UART-1:0]  mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   count;
   logic                  overflow;
   logic                  underflow;

   logic pull_ok;
   logic push_ok;
   logic push_drop;
   logic pull_bad;

   always_comb begin
      pull_ok   = tx_pull_i && (count != '0);
      // A pull in the same cycle frees the slot, so a push at full is still accepted.
      push_ok   = wr_en_i && ((count != FULL_COUNT) || pull_ok);
      push_drop = wr_en_i && !push_ok && !flush_i;
      pull_bad  = tx_pull_i && (count == '0) && !flush_i;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= wr_data_i;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pull_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + {{DEPTH_LOG2{1'b0}}, push_ok} - {{DEPTH_LOG2{1'b0}}, pull_ok};
      end
   end

   // Set beats clear when both happen in the same cycle.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= (overflow && !clear_flags_i) || push_drop;
         underflow <= (underflow && !clear_flags_i) || pull_bad;
      end
   end

   always_comb begin
      tx_load_o   = (count != '0);
      tx_data_o   = mem[rd_ptr];
      full_o      = (count == FULL_COUNT);
      count_o     = count;
      below_thr_o = (count <= thr_i);
      overflow_o  = overflow;
      underflow_o = underflow;
   end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Synchronous show-ahead FIFO that buffers bytes written from the bus-side register interface and serves them to the UART TX controller. It is the responder for the controller's `tx_load`/`tx_full`/`tx_pull` handshake: it presents the head byte and its valid flag, and advances on a one-cycle pull pulse. It also provides occupancy, a programmable low-water flag for TX interrupts, and sticky error flags.

## Interface
- `DATA_UART`, 8: byte width.
- `DEPTH_LOG2`, 4: log2 of the FIFO depth (depth = 2^DEPTH_LOG2 = 16).
- `clk_i` in 1: clock, clk_i.
- `rstn_i` in 1: reset rstn_i, asynchronous, active-low.
- `flush_i` in 1: synchronous flush; empties the FIFO.
- `wr_en_i` in 1: bus-side push strobe.
- `wr_data_i` in DATA_UART: byte to push.
- `clear_flags_i` in 1: clears the sticky overflow and underflow flags.
- `thr_i` in DEPTH_LOG2+1: low-water threshold.
- `tx_pull_i` in 1: controller pull pulse; consumes the head entry.
- `tx_load_o` out 1: FIFO non-empty; the head is valid.
- `tx_data_o` out DATA_UART: head entry (show-ahead).
- `full_o` out 1: count == DEPTH; drives the controller's `tx_full_i`.
- `count_o` out DEPTH_LOG2+1: occupancy, 0..DEPTH.
- `below_thr_o` out 1: count_o <= thr_i.
- `overflow_o` out 1: sticky; a push was dropped.
- `underflow_o` out 1: sticky; a pull arrived while empty.

## Operation
- Storage is 2^DEPTH_LOG2 × DATA_UART registers.
- Write and read pointers are DEPTH_LOG2 bits wide and wrap naturally (15 → 0 at the default depth).
- count is a register DEPTH_LOG2+1 bits wide. It is not derived from the pointers.
- tx_data_o = mem[rd_ptr], read combinationally. It is only meaningful while tx_load_o = 1.
- tx_load_o = (count != 0). full_o = (count == DEPTH). below_thr_o is combinational on count and thr_i.
- Push acceptance:
  - Accepted if wr_en_i && (count < DEPTH || pull_ok).
  - On acceptance: mem[wr_ptr] <= wr_data_i, then wr_ptr increments.
- Pull acceptance:
  - pull_ok = tx_pull_i && count != 0.
  - On acceptance: rd_ptr increments.
- Count update: count += push_ok - pull_ok.
  - Push and pull in the same cycle while full: both accepted, count stays DEPTH.
  - Push and pull in the same cycle while empty: push accepted, pull rejected, count becomes 1, underflow_o sets.
- Errors:
  - wr_en_i while full without an accepted pull: data dropped, overflow_o sets.
  - tx_pull_i while count == 0: rd_ptr unchanged, underflow_o sets.
- Flush has priority over everything except reset:
  - wr_ptr, rd_ptr and count go to 0.
  - Any push or pull in the same cycle is ignored and sets no flags.
  - Sticky flags are unchanged.
  - Memory contents are not cleared.
- clear_flags_i clears both sticky flags. If a new error occurs in the same cycle, the set wins.
- Reset:
  - Pointers, count and flags go to 0. Memory is also reset to 0.
  - Output values after reset: tx_load_o=0, tx_data_o=0, full_o=0, count_o=0, below_thr_o=1 (for any thr_i ≥ 0), overflow_o=0, underflow_o=0.
  - Reset asserted mid-operation discards all contents immediately and asynchronously.

## Timing
- A push accepted at edge N is visible from edge N+1: tx_load_o, tx_data_o (if the FIFO was empty), count_o, full_o.
- A pull at edge N takes effect from edge N+1: the next entry appears on tx_data_o and count decrements.
  - The controller samples tx_data_o in the same cycle it raises tx_pull_o, so a single-cycle pull never loses data.
- tx_pull_i is treated as a level on every cycle. Each high cycle consumes one entry; the FIFO does no edge detection.
- Sticky flags assert at the edge following the offending cycle.
- Flush takes effect at the following edge.
- No combinational path from wr_en_i or tx_pull_i to any output.

## Test plan
- **Reset, fill and drain:**
  - After reset, check all outputs at the values listed above.
  - Push 0x00..0x0F: full_o=1 at the edge after the 16th push, count_o=16.
  - Pull 16 times: bytes come out in order 0x00..0x0F, then tx_load_o=0.
- **Wrap-around:**
  - Push 10, pull 10, then push 12 bytes 0xA0..0xAB.
  - Check order is preserved across the pointer wrap and count_o=12.
- **Overflow and simultaneous push/pull at full:**
  - With the FIFO full, push 0x55 with no pull: overflow_o=1, contents unchanged.
  - Push 0x66 together with a pull: count stays 16, head advances, 0x66 comes out last.
  - Assert clear_flags_i: overflow_o=0.
- **Underflow and push+pull while empty:**
  - Pull while empty: underflow_o=1, count_o=0.
  - Push 0x3C together with a pull while empty: count_o=1, tx_data_o=0x3C, underflow_o=1.
- **Flush and threshold:**
  - Set thr_i=4 and push 6 bytes: below_thr_o=0.
  - Flush together with a push: count_o=0, below_thr_o=1, no flags set.
  - Push 0x11: tx_data_o=0x11.
- **Mid-operation reset plus controller co-simulation:**
  - Assert rstn_i low while 5 bytes are queued: all outputs return to their reset values at once.
  - Connect to uart_controller, push "HI" (0x48, 0x49): each byte is pulled exactly once and appears in order on uart_tx_o.
